// File: rtl/qucs_digi_pkg.sv
// Shared types and constants for the digital pattern source/checker pair.
// Purely declarative: no logic, no latency, no flow control.
package qucs_digi_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } checker_state_t;

  // Width that can hold every value 0..plen inclusive.
  function automatic int ptr_w(input int plen);
    return $clog2(plen + 1);
  endfunction

  localparam logic [7:0] DFLT_PATTERN8 = 8'b1011_0010;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with sticky saturation flag and synchronous clear.
// One-cycle update latency; no backpressure, inc is ignored once at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o,
  output logic         sat_o
);

  localparam logic [W-1:0] MAX = '1;

  logic [W-1:0] cnt_q;
  logic         sat_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else if (clr_i) begin
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else if (inc_i && (cnt_q != MAX)) begin
      cnt_q <= cnt_q + W'(1);
      if (cnt_q == MAX - W'(1)) sat_q <= 1'b1;
    end
  end

  assign cnt_o = cnt_q;
  assign sat_o = sat_q;

endmodule

// File: rtl/prbs_pattern_checker.sv
// Aligns a serial stream to a repeating PAT_LEN-bit pattern, locks, counts bit errors.
// Outputs registered, one clk after the consuming edge; no backpressure, bits taken on en && din_valid.
module prbs_pattern_checker
  import qucs_digi_pkg::*;
#(
  parameter int                 PAT_LEN  = 8,
  parameter logic [PAT_LEN-1:0] PATTERN  = PAT_LEN'(DFLT_PATTERN8),
  parameter int                 LOCK_CNT = 3,
  parameter int                 LOSS_ERR = 3,
  parameter int                 ERR_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             din,
  input  logic             din_valid,
  input  logic             clear,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic             err_sat,
  output logic [1:0]       state_o
);

  localparam int           PW   = ptr_w(PAT_LEN);
  localparam int           IW   = $clog2(PAT_LEN);
  localparam logic [PW-1:0] LAST = PW'(PAT_LEN - 1);
  localparam logic [PW-1:0] FULL = PW'(PAT_LEN);

  checker_state_t     state_q, state_d;
  logic [PAT_LEN-1:0] shreg_q, shreg_d;
  logic [PW-1:0]      fill_q, fill_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [3:0]         good_q, good_d;
  logic [PW-1:0]      werr_q, werr_d;
  logic               locked_q, pulse_q, pulse_d;
  logic               inc;

  logic               exp_bit, mism;
  logic [PAT_LEN-1:0] shifted;
  logic [PW-1:0]      fill_inc, ptr_nxt, werr_sum;

  assign exp_bit  = PATTERN[ptr_q[IW-1:0]];
  assign mism     = (din != exp_bit);
  assign shifted  = {shreg_q[PAT_LEN-2:0], din};
  assign fill_inc = (fill_q == FULL) ? fill_q : fill_q + PW'(1);
  assign ptr_nxt  = (ptr_q == '0) ? LAST : ptr_q - PW'(1);
  assign werr_sum = werr_q + PW'(mism);

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    fill_d  = fill_q;
    ptr_d   = ptr_q;
    good_d  = good_q;
    werr_d  = werr_q;
    pulse_d = 1'b0;
    inc     = 1'b0;

    if (state_q != SEARCH && state_q != VERIFY && state_q != LOCKED) begin
      state_d = SEARCH;
      fill_d  = '0;
    end else if (!en) begin
      // Disabling drops alignment entirely; error statistics survive.
      state_d = SEARCH;
      shreg_d = '0;
      fill_d  = '0;
      good_d  = '0;
      werr_d  = '0;
    end else if (din_valid) begin
      case (state_q)
        SEARCH: begin
          shreg_d = shifted;
          fill_d  = fill_inc;
          if (fill_inc == FULL && shifted == PATTERN) begin
            state_d = VERIFY;
            ptr_d   = LAST;
            good_d  = '0;
          end
        end
        VERIFY: begin
          ptr_d = ptr_nxt;
          if (mism) begin
            state_d = SEARCH;
            fill_d  = '0;
          end else if (ptr_q == '0) begin
            good_d = good_q + 4'd1;
            if (good_q + 4'd1 == 4'(LOCK_CNT)) begin
              state_d = LOCKED;
              werr_d  = '0;
            end
          end
        end
        LOCKED: begin
          ptr_d   = ptr_nxt;
          pulse_d = mism;
          inc     = mism;
          if (mism && werr_sum == PW'(LOSS_ERR)) begin
            state_d = SEARCH;
            fill_d  = '0;
            werr_d  = '0;
          end else begin
            werr_d = (ptr_q == '0) ? '0 : werr_sum;
          end
        end
        default: begin
          state_d = SEARCH;
          fill_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= SEARCH;
      shreg_q  <= '0;
      fill_q   <= '0;
      ptr_q    <= '0;
      good_q   <= '0;
      werr_q   <= '0;
      locked_q <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      fill_q   <= fill_d;
      ptr_q    <= ptr_d;
      good_q   <= good_d;
      werr_q   <= werr_d;
      locked_q <= (state_d == LOCKED);
      pulse_q  <= pulse_d;
    end
  end

  sat_counter #(
    .W(ERR_W)
  ) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (clear),
    .inc_i (inc),
    .cnt_o (err_count),
    .sat_o (err_sat)
  );

  assign locked    = locked_q;
  assign err_pulse = pulse_q;
  assign state_o   = state_q;

endmodule

// File: doc/prbs_pattern_checker.md
Name: prbs_pattern_checker

Overview:
- Receive-side companion to the digital pattern source used in mixed-signal schematic testbenches.
- Samples a serial bit stream and aligns to a fixed repeating PAT_LEN-bit pattern.
- Declares lock, then counts bit errors against the expected pattern. The simulator monitors the status outputs.
- Sits between a Verilog-model output net and the digital probe and recorder nets.

Parameters:
- PAT_LEN, 8: pattern length in bits, range 2..32.
- PATTERN, 8'b1011_0010: expected pattern, transmitted MSB first.
- LOCK_CNT, 3: consecutive error-free pattern words needed to declare lock, range 1..15.
- LOSS_ERR, 3: mismatches within one locked pattern word that force loss of lock, range 1..PAT_LEN.
- ERR_W, 16: width of the error counter.

Ports:
- clk  in  1  sole clock; rising edge
- rst_n  in  1  asynchronous active-low reset
- en  in  1  checker enable
- din  in  1  serial data bit
- din_valid  in  1  qualifies din; a bit is consumed only when en and din_valid are both high
- clear  in  1  synchronous clear of err_count and err_sat
- locked  out  1  high while in LOCKED
- err_pulse  out  1  one-cycle pulse for each mismatched bit while LOCKED
- err_count  out  ERR_W  saturating count of mismatches while LOCKED
- err_sat  out  1  sticky; set when err_count reaches all-ones
- state_o  out  2  current state encoding, for the probe

Behaviour:
- Reset: asynchronous on rst_n low.
  - All outputs 0.
  - Shift register 0, bit pointer 0, word and error counters 0.
  - State SEARCH.
  - Release is synchronous to the next clk edge.
- All outputs are registered. Each output reflects a consumed bit one clk after the edge that samples it.
- Cycles without a consumed bit hold all state. err_pulse is 0 on those cycles.
- en low for a cycle: state returns to SEARCH and locked falls next cycle. The shift register and fill count reset. err_count is held.
- Bit pointer: ptr counts PAT_LEN-1 down to 0. Expected bit = PATTERN[ptr]. ptr wraps from 0 to PAT_LEN-1.
- SEARCH:
  - Shift din into the PAT_LEN-bit shift register, LSB in.
  - A fill counter saturates at PAT_LEN.
  - When the fill count reaches PAT_LEN and the register equals PATTERN, go to VERIFY. Set ptr = PAT_LEN-1 and good_words = 0.
  - The comparison uses the register value including the current bit.
  - There is no rotation search. Alignment occurs naturally within one pattern period once the stream is correct.
- VERIFY:
  - Compare each consumed bit with PATTERN[ptr].
  - Any mismatch: go to SEARCH and clear the fill count. err_count is not incremented.
  - At ptr = 0 with no mismatch in the word, good_words increments.
  - When good_words reaches LOCK_CNT, go to LOCKED.
- LOCKED:
  - Compare each bit with PATTERN[ptr].
  - Each mismatch pulses err_pulse and increments err_count, saturating at 2^ERR_W-1. err_sat sets at saturation.
  - word_errs counts mismatches in the current word and clears when ptr wraps.
  - When word_errs reaches LOSS_ERR, go to SEARCH. locked falls on the same edge that err_pulse rises for that bit.
- State encoding: SEARCH = 0, VERIFY = 1, LOCKED = 2. Value 3 is illegal and recovers to SEARCH.
- clear and error on the same edge: clear dominates. err_count = 0 and err_sat = 0. err_pulse still fires.
- clear affects neither lock state nor ptr.
- Width rule: ptr and the fill count are $clog2(PAT_LEN+1) bits. The counter increment is compared against all-ones before adding, so it never wraps.

Decomposition:
- Shared package qucs_digi_pkg:
  - state enum checker_state_t {SEARCH, VERIFY, LOCKED}.
  - PTR_W helper function.
  - Default pattern constant DFLT_PATTERN8, shared with the pattern source block.
- One sub-module: sat_counter, a parameterised-width saturating counter with sync clear and inc. It is used for err_count and reusable by the source's cycle counter.
- Everything else stays in prbs_pattern_checker: FSM, shift register, pointer.

Test Plan:
- Reset mid-lock:
  - Stimulus: clean PATTERN stream, 40 valid bits with LOCK_CNT = 3; then rst_n pulsed low asynchronously between edges.
  - Response: locked = 1 after bit 32 (8 fill bits + 3 words × 8 bits); all outputs 0 immediately on rst_n low.
- Single error while locked:
  - Stimulus: flip 1 bit in word 5.
  - Response: err_pulse high exactly 1 cycle; err_count = 1; locked stays 1.
- Loss of lock:
  - Stimulus: 3 flipped bits in one word, LOSS_ERR = 3.
  - Response: err_count = 3; locked = 0 on the third error's output cycle; relock after 8 + 24 further clean bits.
- VERIFY abort:
  - Stimulus: mismatch during the 2nd verify word.
  - Response: back to SEARCH; err_count stays 0; state_o = 0.
- din_valid gaps:
  - Stimulus: random din_valid at 50% duty cycle on a clean stream.
  - Response: lock after 32 consumed bits regardless of gaps; no err_pulse.
- Saturation:
  - Stimulus: ERR_W = 4; inverted stream while forced locked with LOSS_ERR = PAT_LEN.
  - Response: err_count sticks at 15; err_sat = 1.
- Clear vs error collision:
  - Stimulus: clear asserted on the same edge as an error.
  - Response: err_count = 0, err_sat = 0, err_pulse = 1.
